instruction_serializer: RTL and testbench

//   Transmit side of the instruction byte stream. Accepts one complete

---
 rtl/instr_pkg.sv | 20 ++
 rtl/instr_len_decode.sv | 11 +
 rtl/instruction_serializer.sv | 98 +++++++++
 tb/tb_instruction_serializer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: length-code field location and word counts.
// Used by instruction_serializer and instruction_register.
package instr_pkg;
   localparam int OP_LEN_CODE_MSB = 7;
   localparam int OP_LEN_CODE_LSB = 6;

   localparam logic [1:0] LEN_1            = 2'd1;
   localparam logic [1:0] LEN_2            = 2'd2;
   localparam logic [1:0] LEN_3            = 2'd3;
   localparam logic [1:0] LEN_CODE_ILLEGAL = 2'b11;

   // Illegal code still maps to a full 3-word instruction so the stream stays aligned.
   function automatic logic [1:0] op_len(input logic [1:0] code);
      case (code)
         2'b00:   return LEN_1;
         2'b01:   return LEN_2;
         default: return LEN_3;
      endcase
   endfunction
endpackage

// File: rtl/instr_len_decode.sv
// Combinational decode of an instruction length code into word count and illegal flag.
module instr_len_decode
   import instr_pkg::*;
(
   input  logic [1:0] i_code,
   output logic [1:0] o_len,
   output logic       o_illegal
);
   assign o_len     = op_len(i_code);
   assign o_illegal = (i_code == LEN_CODE_ILLEGAL);
endmodule

// File: rtl/instruction_serializer.sv
// Serializes a 1..3 word instruction onto a valid/ready word bus, MSB word first.
// Optional out_last output enabled by defining INSTR_SER_LAST_EN.
//
//   state   | meaning
//   --------+----------------------------------------------
//   IDLE    | no instruction held, in_ready high
//   SEND    | presenting buffer word[idx] with out_valid
module instruction_serializer
   import instr_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3*WORD_W-1:0] opcode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_word,
   output logic                len_err
`ifdef INSTR_SER_LAST_EN
   ,
   output logic                out_last
`endif
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]          r_state;
   logic [3*WORD_W-1:0] r_buf;
   logic [1:0]          r_idx;
   logic [1:0]          r_len;
   logic                r_len_err;

   logic [1:0]          w_dec_len;
   logic                w_dec_illegal;
   logic                w_send;
   logic                w_last;
   logic                w_beat;
   logic                w_accept;
   logic [WORD_W-1:0]   w_word;

   instr_len_decode u_len_decode (
      .i_code    (opcode[2*WORD_W+OP_LEN_CODE_MSB : 2*WORD_W+OP_LEN_CODE_LSB]),
      .o_len     (w_dec_len),
      .o_illegal (w_dec_illegal)
   );

   assign w_send   = (r_state == ST_SEND);
   assign w_last   = (r_idx == (r_len - 2'd1));
   assign w_beat   = w_send & out_ready;
   // Last beat frees the buffer in the same cycle, giving zero-bubble streaming.
   assign in_ready = ~w_send | (w_beat & w_last);
   assign w_accept = in_valid & in_ready;

   always_comb begin
      w_word = '0;
      case (r_idx)
         2'd0:    w_word = r_buf[3*WORD_W-1:2*WORD_W];
         2'd1:    w_word = r_buf[2*WORD_W-1:WORD_W];
         2'd2:    w_word = r_buf[WORD_W-1:0];
         default: w_word = '0;
      endcase
   end

   assign out_valid = w_send;
   assign out_word  = w_send ? w_word : '0;
   assign len_err   = r_len_err;

`ifdef INSTR_SER_LAST_EN
   assign out_last  = w_send & w_last;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_buf     <= '0;
         r_idx     <= 2'd0;
         r_len     <= 2'd0;
         r_len_err <= 1'b0;
      end else begin
         r_len_err <= w_accept & w_dec_illegal;
         if (w_accept) begin
            r_state <= ST_SEND;
            r_buf   <= opcode;
            r_idx   <= 2'd0;
            r_len   <= w_dec_len;
         end else if (w_beat) begin
            if (w_last) begin
               r_state <= ST_IDLE;
            end else begin
               r_idx <= r_idx + 2'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_instruction_serializer.sv
// Bench for instruction_serializer: directed vector table, reset corner case,
// and random traffic against a word-queue reference model.
module tb_instruction_serializer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [23:0] opcode = '0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_word;
   logic        len_err;
`ifdef INSTR_SER_LAST_EN
   logic        out_last;
`endif

   instruction_serializer #(.WORD_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .len_err   (len_err)
`ifdef INSTR_SER_LAST_EN
      ,
      .out_last  (out_last)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: words still to be emitted for the current instruction.
   logic [7:0] q[$];
   logic       m_err = 1'b0;

   typedef struct {
      logic        iv;
      logic [23:0] op;
      logic        ordy;
      logic        ev;
      logic [7:0]  ew;
      logic        er;
      logic        ee;
   } vec_t;

   vec_t tbl[25];

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [23:0] op, input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      opcode    = op;
      out_ready = ordy;
      #1;
   endtask

   function automatic logic m_ready();
      return (q.size() == 0) || (q.size() == 1 && out_ready);
   endfunction

   task automatic check_model();
      logic mv;
      mv = (q.size() > 0);
      chk_b("model_valid", out_valid, mv);
      chk_w("model_word", out_word, mv ? q[0] : 8'h00);
      chk_b("model_in_ready", in_ready, m_ready());
      chk_b("model_len_err", len_err, m_err);
`ifdef INSTR_SER_LAST_EN
      chk_b("model_last", out_last, q.size() == 1);
`endif
   endtask

   task automatic tick();
      logic       acc;
      logic [1:0] code;
      int         n;
      acc  = in_valid && m_ready();
      code = opcode[23:22];
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      m_err = acc && (code == 2'b11);
      if (acc) begin
         n = (code == 2'b11) ? 3 : int'(code) + 1;
         q.push_back(opcode[23:16]);
         if (n > 1) q.push_back(opcode[15:8]);
         if (n > 2) q.push_back(opcode[7:0]);
      end
      @(posedge clk);
   endtask

   task automatic set_v(input int i, input logic iv, input logic [23:0] op, input logic ordy,
                        input logic ev, input logic [7:0] ew, input logic er, input logic ee);
      tbl[i] = '{iv, op, ordy, ev, ew, er, ee};
   endtask

   initial begin
      logic [31:0] r;
      // test 1: single word
      set_v(0,  1, 24'h123456, 1, 0, 8'h00, 1, 0);
      set_v(1,  0, 24'h000000, 1, 1, 8'h12, 1, 0);
      set_v(2,  0, 24'h000000, 1, 0, 8'h00, 1, 0);
      // test 2: three words
      set_v(3,  1, 24'h8ABBCC, 1, 0, 8'h00, 1, 0);
      set_v(4,  0, 24'h000000, 1, 1, 8'h8A, 0, 0);
      set_v(5,  0, 24'h000000, 1, 1, 8'hBB, 0, 0);
      set_v(6,  0, 24'h000000, 1, 1, 8'hCC, 1, 0);
      set_v(7,  0, 24'h000000, 1, 0, 8'h00, 1, 0);
      // test 3: stall on the last word
      set_v(8,  1, 24'h412200, 1, 0, 8'h00, 1, 0);
      set_v(9,  0, 24'h000000, 1, 1, 8'h41, 0, 0);
      set_v(10, 0, 24'h000000, 0, 1, 8'h22, 0, 0);
      set_v(11, 0, 24'h000000, 0, 1, 8'h22, 0, 0);
      set_v(12, 0, 24'h000000, 1, 1, 8'h22, 1, 0);
      set_v(13, 0, 24'h000000, 1, 0, 8'h00, 1, 0);
      // test 4: back to back, in_valid held while busy
      set_v(14, 1, 24'h401111, 1, 0, 8'h00, 1, 0);
      set_v(15, 1, 24'h556677, 1, 1, 8'h40, 0, 0);
      set_v(16, 1, 24'h556677, 1, 1, 8'h11, 1, 0);
      set_v(17, 0, 24'h000000, 1, 1, 8'h55, 0, 0);
      set_v(18, 0, 24'h000000, 1, 1, 8'h66, 1, 0);
      set_v(19, 0, 24'h000000, 1, 0, 8'h00, 1, 0);
      // test 5: illegal length code
      set_v(20, 1, 24'hC01122, 1, 0, 8'h00, 1, 0);
      set_v(21, 0, 24'h000000, 1, 1, 8'hC0, 0, 1);
      set_v(22, 0, 24'h000000, 1, 1, 8'h11, 0, 0);
      set_v(23, 0, 24'h000000, 1, 1, 8'h22, 1, 0);
      set_v(24, 0, 24'h000000, 1, 0, 8'h00, 1, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_b("reset_out_valid", out_valid, 1'b0);
      chk_w("reset_out_word", out_word, 8'h00);
      chk_b("reset_len_err", len_err, 1'b0);
`ifdef INSTR_SER_LAST_EN
      chk_b("reset_out_last", out_last, 1'b0);
`endif
      rst_n = 1'b1;
      #1;
      chk_b("reset_in_ready", in_ready, 1'b1);

      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].iv, tbl[i].op, tbl[i].ordy);
         chk_b($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         chk_w($sformatf("tbl%0d_word", i), out_word, tbl[i].ew);
         chk_b($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].er);
         chk_b($sformatf("tbl%0d_len_err", i), len_err, tbl[i].ee);
         check_model();
         tick();
      end

      // test 6: reset asserted while the second of three words is presented
      drive(1, 24'h8ABBCC, 1);
      check_model();
      tick();
      drive(0, 24'h000000, 1);
      chk_w("rst6_word1", out_word, 8'h8A);
      tick();
      drive(0, 24'h000000, 1);
      chk_w("rst6_word2", out_word, 8'hBB);
      #1 rst_n = 1'b0;
      #1;
      chk_b("rst6_valid_during_reset", out_valid, 1'b0);
      q.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 24'h000000, 1);
         chk_b("rst6_no_resend", out_valid, 1'b0);
         check_model();
         tick();
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom();
         drive(($urandom_range(0, 2) != 0), r[23:0], ($urandom_range(0, 3) != 0));
         check_model();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
